pc_fetch_stage: RTL and testbench
=================================

# pc_fetch_stage

Instruction-fetch stage that sits directly downstream of the PC select mux. It holds the program counter, loads the mux result as the next PC, and drives the instruction-memory request. It exposes `pc_plus4` back to the mux as its sequential input, and latches the fetched instruction into the IF/ID pipeline register with stall, flush and memory-wait handling.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `NOP_INSTR`, 32'h0000_0000, instruction word placed in IF/ID on bubble or flush
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `next_pc`  in  32  selected next PC from the PC mux
- `stall`  in  1  hazard-unit hold request: freeze PC and IF/ID
- `flush`  in  1  redirect/squash request: bubble IF/ID, load `next_pc`
- `imem_ready`  in  1  instruction memory has valid `imem_rdata` for `imem_addr` this cycle
- `imem_rdata`  in  32  instruction word
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address, equal to `pc`
- `pc`  out  32  current PC
- `pc_plus4`  out  32  combinational `pc + 4`, fed to the PC mux
- `ifid_instr`  out  32  IF/ID instruction
- `ifid_pc_plus4`  out  32  IF/ID copy of `pc + 4` for the fetched instruction
- `ifid_valid`  out  1  IF/ID holds a real instruction

## Operation
- States: FETCH (request outstanding) and HELD (instruction captured in the internal buffer while stalled). `imem_req` = (state==FETCH) && !rst.
- PC load always writes `{next_pc[31:2], 2'b00}`. `pc_plus4` wraps modulo 2^32.
- Priority each cycle: `rst` > `flush` > `stall` > normal.
- Any state, `flush`:
  - `pc` <= `next_pc`
  - `ifid_valid` <= 0, `ifid_instr` <= `NOP_INSTR`
  - buffer discarded; state -> FETCH
  - any `imem_ready` that cycle is ignored.
- FETCH, `stall`:
  - IF/ID and `pc` hold.
  - If `imem_ready`: buffer <= {`imem_rdata`, `pc_plus4`}; state -> HELD.
- FETCH, normal, `imem_ready`:
  - IF/ID <= {`imem_rdata`, `pc_plus4`, valid=1}
  - `pc` <= `next_pc`.
- FETCH, normal, !`imem_ready`:
  - `ifid_valid` <= 0, `ifid_instr` <= `NOP_INSTR` (bubble)
  - `pc` holds.
- HELD, `stall`: everything holds; `imem_req` = 0.
- HELD, normal:
  - IF/ID <= buffer, valid=1
  - `pc` <= `next_pc`
  - state -> FETCH.
- The memory accepts an address change while `imem_req` is held; `imem_ready` always refers to the current-cycle `imem_addr`.

## Timing
- Reset values:
  - `pc` = `RESET_PC`
  - `ifid_instr` = `NOP_INSTR`, `ifid_pc_plus4` = 0, `ifid_valid` = 0
  - state = FETCH, buffer = 0
  - `imem_req` = 0 while `rst` is high.
- Reset is synchronous: asserting `rst` mid-HELD or mid-wait discards everything on the next edge.
- Throughput: one instruction per cycle when `imem_ready` is continuously high.
- Fetch-to-IF/ID latency: the instruction appears on `ifid_*` one edge after the `imem_ready` cycle.
- Wait states: each cycle with `imem_ready` low inserts exactly one bubble.
- Stall release from HELD: the buffered instruction reaches IF/ID on the first edge with `stall` low. No refetch is issued and no instruction is lost or duplicated.
- `flush` with `stall` in the same cycle: the flush wins and PC is redirected.
- `pc_plus4`, `imem_addr` and `imem_req` are combinational from registered state; they do not depend on `next_pc`.

## Test plan
- Reset then run:
  - Stimulus: `RESET_PC`=0x100; `imem_ready`=1; `next_pc`=`pc_plus4`.
  - Required: `imem_addr` = 0x100, 0x104, 0x108 on consecutive cycles. `ifid_pc_plus4` = 0x104 with `ifid_valid`=1 one cycle after the 0x100 fetch.
- Memory wait:
  - Stimulus: `imem_ready` low for 2 cycles at PC 0x200.
  - Required: `pc` holds 0x200; two bubbles (`ifid_valid`=0, `ifid_instr`=`NOP_INSTR`); then instruction 0x200 with `ifid_pc_plus4`=0x204.
- Stall with capture:
  - Stimulus: `stall`=1 for 3 cycles while `imem_ready`=1 at PC 0x300 returning 0xAABBCCDD.
  - Required: `imem_req` drops after 1 cycle. IF/ID holds its previous contents. On release, `ifid_instr`=0xAABBCCDD and `pc` advances to 0x304, with no second fetch of 0x300.
- Flush during HELD:
  - Stimulus: `flush`=1 with `next_pc`=0x4000.
  - Required: `ifid_valid`=0, `ifid_instr`=`NOP_INSTR`, `pc`=0x4000, state returns to FETCH, and the buffered word is never emitted.
- Flush+stall same cycle, misaligned target, and wrap-around:
  - Stimulus: `flush`+`stall` with `next_pc`=0x1003; separately, PC at 0xFFFFFFFC.
  - Required: `pc`=0x1000. At 0xFFFFFFFC, `pc_plus4`=0x00000000.
- Reset mid-HELD:
  - Stimulus: assert `rst` for 1 cycle while in HELD.
  - Required: all outputs return to reset values on the next edge, and no buffered instruction appears afterwards.

Source files
------------

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues the instruction-memory request and
// fills the IF/ID register, with a one-entry buffer that parks a word fetched while stalled.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_next_pc,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_imem_ready,
    input  logic [31:0] i_imem_rdata,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_ifid_instr,
    output logic [31:0] o_ifid_pc_plus4,
    output logic        o_ifid_valid
);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HELD  = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pc_plus4;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc_plus4;
    logic        r_ifid_valid;

    state_t      w_state_next;
    logic [31:0] w_pc_next;
    logic [31:0] w_buf_instr_next;
    logic [31:0] w_buf_pc_plus4_next;
    logic [31:0] w_ifid_instr_next;
    logic [31:0] w_ifid_pc_plus4_next;
    logic        w_ifid_valid_next;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_target_pc;

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_target_pc = {i_next_pc[31:2], 2'b00};

    assign o_imem_req      = (r_state == ST_FETCH) && !i_rst;
    assign o_imem_addr     = r_pc;
    assign o_pc            = r_pc;
    assign o_pc_plus4      = w_pc_plus4;
    assign o_ifid_instr    = r_ifid_instr;
    assign o_ifid_pc_plus4 = r_ifid_pc_plus4;
    assign o_ifid_valid    = r_ifid_valid;

    always_comb begin
        w_state_next         = r_state;
        w_pc_next            = r_pc;
        w_buf_instr_next     = r_buf_instr;
        w_buf_pc_plus4_next  = r_buf_pc_plus4;
        w_ifid_instr_next    = r_ifid_instr;
        w_ifid_pc_plus4_next = r_ifid_pc_plus4;
        w_ifid_valid_next    = r_ifid_valid;

        if (i_flush) begin
            // Redirect squashes both IF/ID and any parked word; a same-cycle response is dropped.
            w_pc_next           = w_target_pc;
            w_ifid_valid_next   = 1'b0;
            w_ifid_instr_next   = NOP_INSTR;
            w_buf_instr_next    = 32'h0;
            w_buf_pc_plus4_next = 32'h0;
            w_state_next        = ST_FETCH;
        end else if (i_stall) begin
            if (r_state == ST_FETCH && i_imem_ready) begin
                w_buf_instr_next    = i_imem_rdata;
                w_buf_pc_plus4_next = w_pc_plus4;
                w_state_next        = ST_HELD;
            end
        end else if (r_state == ST_HELD) begin
            w_ifid_instr_next    = r_buf_instr;
            w_ifid_pc_plus4_next = r_buf_pc_plus4;
            w_ifid_valid_next    = 1'b1;
            w_pc_next            = w_target_pc;
            w_state_next         = ST_FETCH;
        end else if (i_imem_ready) begin
            w_ifid_instr_next    = i_imem_rdata;
            w_ifid_pc_plus4_next = w_pc_plus4;
            w_ifid_valid_next    = 1'b1;
            w_pc_next            = w_target_pc;
        end else begin
            w_ifid_valid_next = 1'b0;
            w_ifid_instr_next = NOP_INSTR;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= ST_FETCH;
            r_pc            <= RESET_PC;
            r_buf_instr     <= 32'h0;
            r_buf_pc_plus4  <= 32'h0;
            r_ifid_instr    <= NOP_INSTR;
            r_ifid_pc_plus4 <= 32'h0;
            r_ifid_valid    <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_pc            <= w_pc_next;
            r_buf_instr     <= w_buf_instr_next;
            r_buf_pc_plus4  <= w_buf_pc_plus4_next;
            r_ifid_instr    <= w_ifid_instr_next;
            r_ifid_pc_plus4 <= w_ifid_pc_plus4_next;
            r_ifid_valid    <= w_ifid_valid_next;
        end
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: a transaction-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_pc_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, flush, ready, follow;
    logic [31:0] np_val;
    logic [31:0] next_pc, rdata;
    logic        imem_req, ifid_valid;
    logic [31:0] imem_addr, pc, pc_plus4, ifid_instr, ifid_pc_plus4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .i_clk(clk), .i_rst(rst), .i_next_pc(next_pc), .i_stall(stall), .i_flush(flush),
        .i_imem_ready(ready), .i_imem_rdata(rdata), .o_imem_req(imem_req),
        .o_imem_addr(imem_addr), .o_pc(pc), .o_pc_plus4(pc_plus4), .o_ifid_instr(ifid_instr),
        .o_ifid_pc_plus4(ifid_pc_plus4), .o_ifid_valid(ifid_valid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0300) return 32'hAABB_CCDD;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Instruction memory and PC mux stand-ins
    assign rdata   = mem_word(imem_addr);
    assign next_pc = follow ? pc_plus4 : np_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: PC, IF/ID contents, and a queue holding at most one parked fetch
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    logic        m_known = 1'b0;
    logic [63:0] m_park[$];

    always @(negedge clk) begin
        logic [31:0] tgt;
        if (m_known) begin
            chk("pc", pc, m_pc);
            chk("imem_addr", imem_addr, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("imem_req", {31'b0, imem_req}, {31'b0, (m_park.size() == 0) && !rst});
            chk("ifid_instr", ifid_instr, m_instr);
            chk("ifid_pc_plus4", ifid_pc_plus4, m_pc4);
            chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
        end
        tgt = (follow ? m_pc + 32'd4 : np_val) & 32'hFFFF_FFFC;
        if (rst) begin
            m_known = 1'b1;
            m_pc = RST_PC; m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0;
            m_park.delete();
        end else if (m_known) begin
            if (flush) begin
                m_pc = tgt; m_instr = NOP; m_valid = 1'b0;
                m_park.delete();
            end else if (stall) begin
                if (m_park.size() == 0 && ready)
                    m_park.push_back({mem_word(m_pc), m_pc + 32'd4});
            end else if (m_park.size() != 0) begin
                {m_instr, m_pc4} = m_park.pop_front();
                m_valid = 1'b1; m_pc = tgt;
            end else if (ready) begin
                m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = tgt;
            end else begin
                m_instr = NOP; m_valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; ready = 1'b1; follow = 1'b1; np_val = 32'h0;
        settle();
        chk("req_in_reset", {31'b0, imem_req}, 32'h0);
        tick(); tick();

        // Reset then run
        rst = 1'b0; settle();
        chk("run_addr0", imem_addr, 32'h100);
        chk("run_req", {31'b0, imem_req}, 32'h1);
        chk("run_ifid_valid0", {31'b0, ifid_valid}, 32'h0);
        tick();
        chk("run_addr1", imem_addr, 32'h104);
        chk("run_ifid_pc4", ifid_pc_plus4, 32'h104);
        chk("run_ifid_valid", {31'b0, ifid_valid}, 32'h1);
        chk("run_ifid_instr", ifid_instr, 32'h0100_FEFF);
        tick();
        chk("run_addr2", imem_addr, 32'h108);

        // Memory wait at 0x200
        follow = 1'b0; np_val = 32'h200; tick();
        follow = 1'b1; ready = 1'b0; tick();
        chk("wait_pc1", pc, 32'h200);
        chk("wait_bubble1", {31'b0, ifid_valid}, 32'h0);
        chk("wait_nop1", ifid_instr, NOP);
        tick();
        chk("wait_pc2", pc, 32'h200);
        chk("wait_bubble2", {31'b0, ifid_valid}, 32'h0);
        ready = 1'b1; tick();
        chk("wait_instr", ifid_instr, 32'h0200_FDFF);
        chk("wait_pc4", ifid_pc_plus4, 32'h204);

        // Stall with capture at 0x300
        follow = 1'b0; np_val = 32'h300; tick();
        follow = 1'b1; stall = 1'b1; settle();
        chk("stall_req_c1", {31'b0, imem_req}, 32'h1);
        tick();
        chk("stall_req_c2", {31'b0, imem_req}, 32'h0);
        chk("stall_ifid_hold", ifid_pc_plus4, 32'h208);
        tick();
        chk("stall_req_c3", {31'b0, imem_req}, 32'h0);
        tick();
        stall = 1'b0; settle();
        chk("stall_req_rel", {31'b0, imem_req}, 32'h0);
        tick();
        chk("stall_rel_instr", ifid_instr, 32'hAABB_CCDD);
        chk("stall_rel_pc4", ifid_pc_plus4, 32'h304);
        chk("stall_rel_pc", pc, 32'h304);
        chk("stall_rel_addr", imem_addr, 32'h304);

        // Flush during HELD
        stall = 1'b1; tick();
        stall = 1'b0; flush = 1'b1; follow = 1'b0; np_val = 32'h4000; tick();
        chk("flush_valid", {31'b0, ifid_valid}, 32'h0);
        chk("flush_instr", ifid_instr, NOP);
        chk("flush_pc", pc, 32'h4000);
        chk("flush_req", {31'b0, imem_req}, 32'h1);
        flush = 1'b0; follow = 1'b1; tick();
        chk("flush_next_pc4", ifid_pc_plus4, 32'h4004);

        // Flush+stall with misaligned target, then wrap-around
        flush = 1'b1; stall = 1'b1; follow = 1'b0; np_val = 32'h1003; tick();
        chk("fs_pc", pc, 32'h1000);
        chk("fs_valid", {31'b0, ifid_valid}, 32'h0);
        stall = 1'b0; np_val = 32'hFFFF_FFFC; tick();
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4, 32'h0);
        flush = 1'b0; follow = 1'b1; tick();
        chk("wrap_ifid_pc4", ifid_pc_plus4, 32'h0);
        chk("wrap_pc_after", pc, 32'h0);

        // Reset mid-HELD
        stall = 1'b1; tick();
        chk("held_req", {31'b0, imem_req}, 32'h0);
        rst = 1'b1; tick();
        chk("rst_pc", pc, RST_PC);
        chk("rst_instr", ifid_instr, NOP);
        chk("rst_pc4", ifid_pc_plus4, 32'h0);
        chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
        rst = 1'b0; stall = 1'b0; settle();
        chk("rst_req_after", {31'b0, imem_req}, 32'h1);
        tick();
        chk("rst_no_buf_pc4", ifid_pc_plus4, 32'h104);
        chk("rst_no_buf_instr", ifid_instr, 32'h0100_FEFF);

        // Mixed traffic for the per-cycle model
        for (int i = 0; i < 10; i++) begin
            ready = (i % 3) != 0;
            stall = (i == 4) || (i == 5);
            tick();
        end
        stall = 1'b0; ready = 1'b1; tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
